coef_page_sched: RTL

Page scheduler and MCU sequencer for the triple-buffered dequantized-coefficient store between the shuffle stage and the IDCT. It tells the shuffle writer which page to fill and the IDCT reader which page holds a complete block. It supplies the component type and quantization-table select for each block, and stalls the Huffman front end when no free page exists. It also issues a page-clear request whenever the reader releases a page.

---
 rtl/jpeg_sched_pkg.sv | 61 ++++++
 rtl/coef_page_sched_mcu_seq.sv | 58 +++++
 rtl/coef_page_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/jpeg_sched_pkg.sv
// Shared encodings and lookup helpers for the coefficient page scheduler.
// Maps (mode, block index) to the component stored in that block and the MCU length.
package jpeg_sched_pkg;

   localparam int PAGES = 3;
   localparam int ROWS  = 8;

   typedef enum logic [1:0] {
      COMP_NONE = 2'd0,
      COMP_Y    = 2'd1,
      COMP_U    = 2'd2,
      COMP_V    = 2'd3
   } comp_e;

   typedef enum logic [1:0] {
      MODE_GRAY = 2'd0,
      MODE_444  = 2'd1,
      MODE_420  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef struct packed {
      comp_e      comp;
      logic [2:0] len;
   } seq_info_t;

   function automatic seq_info_t seq_lookup(input mode_e mode, input logic [2:0] idx);
      seq_info_t info;
      info.comp = COMP_Y;
      info.len  = 3'd1;
      case (mode)
         MODE_444: begin
            info.len = 3'd3;
            case (idx)
               3'd1:    info.comp = COMP_U;
               3'd2:    info.comp = COMP_V;
               default: info.comp = COMP_Y;
            endcase
         end
         MODE_420: begin
            info.len = 3'd6;
            case (idx)
               3'd4:    info.comp = COMP_U;
               3'd5:    info.comp = COMP_V;
               default: info.comp = COMP_Y;
            endcase
         end
         default: begin
            // Reserved mode behaves as grayscale.
            info.comp = COMP_Y;
            info.len  = 3'd1;
         end
      endcase
      return info;
   endfunction

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/coef_page_sched_mcu_seq.sv
// MCU block sequencer: latched mode, block index and the per-block component outputs.
// Outputs are registered with the values for the block that will be written next.
module mcu_seq
   import jpeg_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cfg_mode,
   input  logic       cfg_load,
   input  logic       blk_adv,
   output logic [1:0] data_type,
   output logic       quan_tb_sel,
   output logic       mcu_done
);

   mode_e      mode_r;
   mode_e      mode_next_s;
   logic [2:0] idx_r;
   logic [2:0] idx_next_s;
   logic       wrap_s;
   seq_info_t  info_cur_s;
   seq_info_t  info_next_s;

   // Next mode/index; a concurrent block still wraps against the old sequence.
   always_comb begin
      info_cur_s  = seq_lookup(mode_r, idx_r);
      wrap_s      = blk_adv && (idx_r == (info_cur_s.len - 3'd1));
      mode_next_s = mode_r;
      idx_next_s  = idx_r;
      if (cfg_load) begin
         mode_next_s = mode_e'(cfg_mode);
         idx_next_s  = 3'd0;
      end else if (blk_adv) begin
         idx_next_s = wrap_s ? 3'd0 : (idx_r + 3'd1);
      end else begin
         idx_next_s = idx_r;
      end
      info_next_s = seq_lookup(mode_next_s, idx_next_s);
   end

   // Sequencer state and registered block descriptors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r      <= MODE_GRAY;
         idx_r       <= 3'd0;
         data_type   <= COMP_Y;
         quan_tb_sel <= 1'b0;
         mcu_done    <= 1'b0;
      end else begin
         mode_r      <= mode_next_s;
         idx_r       <= idx_next_s;
         data_type   <= info_next_s.comp;
         quan_tb_sel <= (info_next_s.comp != COMP_Y);
         mcu_done    <= wrap_s;
      end
   end

endmodule

// File: rtl/coef_page_sched.sv
// Triple-buffered coefficient page scheduler between shuffle writer and IDCT reader.
// Holds page pointers, fill count, per-page component tags and the row read handshake.
module coef_page_sched
   import jpeg_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cfg_mode,
   input  logic       cfg_load,
   input  logic       blk_done,
   output logic [1:0] wr_page,
   output logic       wr_stall,
   output logic [1:0] data_type,
   output logic       quan_tb_sel,
   output logic       mcu_done,
   output logic       rd_valid,
   output logic [1:0] rd_page,
   output logic [2:0] rd_row,
   output logic [1:0] rd_type,
   input  logic       rd_ready,
   output logic       rd_last,
   output logic       clr_req,
   output logic [1:0] clr_page,
   output logic [1:0] full_cnt,
   output logic       ovf_err
);

   logic [1:0] wr_ptr_r;
   logic [1:0] rd_ptr_r;
   logic [1:0] full_cnt_r;
   logic [1:0] full_next_s;
   logic [2:0] rd_row_r;
   logic [1:0] tag_r [PAGES];
   logic       clr_req_r;
   logic [1:0] clr_page_r;
   logic       ovf_err_r;
   logic       wr_stall_s;
   logic       rd_valid_s;
   logic       wr_acc_s;
   logic       rd_xfer_s;
   logic       rd_rel_s;

   mcu_seq u_mcu_seq (
      .clk         (clk),
      .rst         (rst),
      .cfg_mode    (cfg_mode),
      .cfg_load    (cfg_load),
      .blk_adv     (wr_acc_s),
      .data_type   (data_type),
      .quan_tb_sel (quan_tb_sel),
      .mcu_done    (mcu_done)
   );

   // Handshake qualifiers and fill-count update; completion and release together cancel.
   always_comb begin
      wr_stall_s = (full_cnt_r == 2'd3);
      rd_valid_s = (full_cnt_r != 2'd0);
      wr_acc_s   = blk_done && !wr_stall_s;
      rd_xfer_s  = rd_valid_s && rd_ready;
      rd_rel_s   = rd_xfer_s && (rd_row_r == 3'(ROWS - 1));
      case ({wr_acc_s, rd_rel_s})
         2'b10:   full_next_s = full_cnt_r + 2'd1;
         2'b01:   full_next_s = full_cnt_r - 2'd1;
         default: full_next_s = full_cnt_r;
      endcase
   end

   // Page pointers, tags, row counter, clear request and overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= 2'd0;
         rd_ptr_r   <= 2'd0;
         full_cnt_r <= 2'd0;
         rd_row_r   <= 3'd0;
         clr_req_r  <= 1'b0;
         clr_page_r <= 2'd0;
         ovf_err_r  <= 1'b0;
         for (int i = 0; i < PAGES; i++) begin
            tag_r[i] <= COMP_Y;
         end
      end else begin
         full_cnt_r <= full_next_s;
         clr_req_r  <= rd_rel_s;
         ovf_err_r  <= ovf_err_r | (blk_done & wr_stall_s);
         if (wr_acc_s) begin
            tag_r[wr_ptr_r] <= data_type;
            wr_ptr_r        <= ptr_next(wr_ptr_r);
         end
         if (rd_xfer_s) begin
            rd_row_r <= rd_rel_s ? 3'd0 : (rd_row_r + 3'd1);
         end
         if (rd_rel_s) begin
            rd_ptr_r   <= ptr_next(rd_ptr_r);
            clr_page_r <= rd_ptr_r;
         end
      end
   end

   assign wr_page  = wr_ptr_r;
   assign wr_stall = wr_stall_s;
   assign rd_valid = rd_valid_s;
   assign rd_page  = rd_ptr_r;
   assign rd_row   = rd_row_r;
   assign rd_type  = tag_r[rd_ptr_r];
   assign rd_last  = rd_valid_s && (rd_row_r == 3'(ROWS - 1));
   assign clr_req  = clr_req_r;
   assign clr_page = clr_page_r;
   assign full_cnt = full_cnt_r;
   assign ovf_err  = ovf_err_r;

endmodule
